// File: rtl/mii_uart_mux.sv
// mii_uart_mux: merges byte strobes from up to four MII receivers through one shared
// FIFO onto a single UART transmitter, optionally framed with HDLC-style stuffing.
module mii_uart_mux #(
   parameter int CHANNELS   = 2,
   parameter int DEPTH_LOG2 = 7,
   parameter int FRAME_MODE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   ch_rdy,
   input  logic [8*CHANNELS-1:0] ch_q,
   input  logic [CHANNELS-1:0]   ch_en,
   input  logic                  tx_active,
   output logic                  tx_dv,
   output logic [7:0]            tx_byte,
   output logic [CHANNELS-1:0]   overflow,
   output logic [DEPTH_LOG2:0]   fifo_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, EMIT1 = 2'd1, EMIT2 = 2'd2} state_t;

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [1:0] KIND_DATA = 2'd0;
   localparam logic [1:0] KIND_SOF  = 2'd1;
   localparam logic [1:0] KIND_EOF  = 2'd2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

   logic [CHANNELS-1:0]   rdy_q, en_q;
   logic [CHANNELS-1:0]   pend_sof_q, pend_sof_d, pend_data_q, pend_data_d, pend_eof_q, pend_eof_d;
   logic [8*CHANNELS-1:0] stage_q, stage_d;
   logic [CHANNELS-1:0]   ovf_q, ovf_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [CHANNELS-1:0]   rdy_rise, en_rise, en_fall;

   logic [11:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  full, pop, wr_en, found;
   logic [CHANNELS-1:0]   gnt_oh;
   logic [1:0]            gnt_ch, wr_kind, nxt_ptr;
   logic [7:0]            wr_byte;

   state_t                state_q, state_d;
   logic [11:0]           cur_q, cur_d;
   logic [7:0]            sec_q, sec_d;
   logic                  more_q, more_d;
   logic [1:0]            last_ch_q, last_ch_d;
   logic                  tx_dv_q, tx_dv_d;
   logic [7:0]            tx_byte_q, tx_byte_d;
   logic                  can_issue;
   logic [1:0]            cur_kind, cur_ch;
   logic [7:0]            cur_byte;

   assign rdy_rise = ch_rdy & ~rdy_q;
   assign en_rise  = ch_en & ~en_q;
   assign en_fall  = ~ch_en & en_q;
   assign full     = (count_q == FULL_CNT);
   assign pop      = (state_q == IDLE) && (count_q != (DEPTH_LOG2+1)'(0));

   // Round-robin grant starting at ptr_q; the grant picks SOF, then data, then EOF.
   always_comb begin
      found   = 1'b0;
      gnt_oh  = {CHANNELS{1'b0}};
      gnt_ch  = 2'd0;
      wr_kind = KIND_EOF;
      wr_byte = 8'h00;
      nxt_ptr = ptr_q;
      for (int i = 0; i < CHANNELS; i++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (!found && (c == (int'(ptr_q) + i) % CHANNELS) &&
                (pend_sof_q[c] || pend_data_q[c] || pend_eof_q[c])) begin
               found     = 1'b1;
               gnt_oh[c] = 1'b1;
               gnt_ch    = 2'(c);
               nxt_ptr   = 2'((c + 1) % CHANNELS);
               if (pend_sof_q[c]) begin
                  wr_kind = KIND_SOF;
               end else if (pend_data_q[c]) begin
                  wr_kind = KIND_DATA;
                  wr_byte = stage_q[8*c +: 8];
               end else begin
                  wr_kind = KIND_EOF;
               end
            end
         end
      end
      wr_en = found && !full;
      ptr_d = wr_en ? nxt_ptr : ptr_q;
   end

   // Clears from the grant are applied before sets so a same-cycle set wins without overrun.
   always_comb begin
      pend_sof_d  = pend_sof_q;
      pend_data_d = pend_data_q;
      pend_eof_d  = pend_eof_q;
      stage_d     = stage_q;
      ovf_d       = ovf_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (wr_en && gnt_oh[c]) begin
            case (wr_kind)
               KIND_SOF:  pend_sof_d[c]  = 1'b0;
               KIND_DATA: pend_data_d[c] = 1'b0;
               default:   pend_eof_d[c]  = 1'b0;
            endcase
         end
         if (rdy_rise[c]) begin
            if (pend_data_d[c]) begin
               ovf_d[c] = 1'b1;
            end else begin
               pend_data_d[c]     = 1'b1;
               stage_d[8*c +: 8] = ch_q[8*c +: 8];
            end
         end
         if (FRAME_MODE != 0 && en_rise[c]) begin
            if (pend_sof_d[c]) ovf_d[c] = 1'b1;
            else               pend_sof_d[c] = 1'b1;
         end
         if (FRAME_MODE != 0 && en_fall[c]) begin
            if (pend_eof_d[c]) ovf_d[c] = 1'b1;
            else               pend_eof_d[c] = 1'b1;
         end
      end
   end

   always_comb begin
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
         default: count_d = count_q;
      endcase
   end

   assign cur_kind  = cur_q[11:10];
   assign cur_ch    = cur_q[9:8];
   assign cur_byte  = cur_q[7:0];
   assign can_issue = !tx_active && !tx_dv_q;

   // Output sequencer: a channel header re-enters EMIT1 so the data byte follows it.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      sec_d     = sec_q;
      more_d    = more_q;
      last_ch_d = last_ch_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               cur_d   = mem[rd_ptr_q];
               state_d = EMIT1;
            end
         end
         EMIT1: begin
            if (can_issue) begin
               tx_dv_d = 1'b1;
               more_d  = 1'b0;
               if (FRAME_MODE == 0) begin
                  tx_byte_d = cur_byte;
                  state_d   = IDLE;
               end else if (cur_kind == KIND_SOF) begin
                  tx_byte_d = 8'h7E;
                  sec_d     = 8'h90 | {6'd0, cur_ch};
                  last_ch_d = cur_ch;
                  state_d   = EMIT2;
               end else if (cur_kind == KIND_EOF) begin
                  tx_byte_d = 8'h7E;
                  sec_d     = 8'hA0 | {6'd0, cur_ch};
                  state_d   = EMIT2;
               end else if (cur_ch != last_ch_q) begin
                  tx_byte_d = 8'h7E;
                  sec_d     = 8'h80 | {6'd0, cur_ch};
                  last_ch_d = cur_ch;
                  more_d    = 1'b1;
                  state_d   = EMIT2;
               end else if (cur_byte == 8'h7E || cur_byte == 8'h7D) begin
                  tx_byte_d = 8'h7D;
                  sec_d     = cur_byte ^ 8'h20;
                  state_d   = EMIT2;
               end else begin
                  tx_byte_d = cur_byte;
                  state_d   = IDLE;
               end
            end
         end
         EMIT2: begin
            if (can_issue) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = sec_q;
               state_d   = more_q ? EMIT1 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {wr_kind, gnt_ch, wr_byte};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdy_q       <= {CHANNELS{1'b0}};
         en_q        <= {CHANNELS{1'b0}};
         pend_sof_q  <= {CHANNELS{1'b0}};
         pend_data_q <= {CHANNELS{1'b0}};
         pend_eof_q  <= {CHANNELS{1'b0}};
         stage_q     <= {(8*CHANNELS){1'b0}};
         ovf_q       <= {CHANNELS{1'b0}};
         ptr_q       <= 2'd0;
         wr_ptr_q    <= DEPTH_LOG2'(0);
         rd_ptr_q    <= DEPTH_LOG2'(0);
         count_q     <= (DEPTH_LOG2+1)'(0);
         state_q     <= IDLE;
         cur_q       <= 12'h000;
         sec_q       <= 8'h00;
         more_q      <= 1'b0;
         last_ch_q   <= 2'd3;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
      end else begin
         rdy_q       <= ch_rdy;
         en_q        <= ch_en;
         pend_sof_q  <= pend_sof_d;
         pend_data_q <= pend_data_d;
         pend_eof_q  <= pend_eof_d;
         stage_q     <= stage_d;
         ovf_q       <= ovf_d;
         ptr_q       <= ptr_d;
         wr_ptr_q    <= wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
         rd_ptr_q    <= pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
         count_q     <= count_d;
         state_q     <= state_d;
         cur_q       <= cur_d;
         sec_q       <= sec_d;
         more_q      <= more_d;
         last_ch_q   <= last_ch_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
      end
   end

   assign tx_dv      = tx_dv_q;
   assign tx_byte    = tx_byte_q;
   assign overflow   = ovf_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_mii_uart_mux.sv
// Directed bench for mii_uart_mux: raw, framed and small-FIFO instances, each driving
// a simple UART busy model and logging every byte handed over on tx_dv.
module tb_mii_uart_mux;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // raw instance: 1 channel, raw bytes
   logic [0:0] r_rdy, r_en, r_ovf;
   logic [7:0] r_q, r_byte, r_cnt;
   logic       r_act, r_dv;
   // framed instance: 2 channels
   logic [1:0]  f_rdy, f_en, f_ovf;
   logic [15:0] f_q;
   logic [7:0]  f_byte, f_cnt;
   logic        f_act, f_dv;
   // small-FIFO instance: 1 channel, depth 4, raw
   logic [0:0] s_rdy, s_en, s_ovf;
   logic [7:0] s_q, s_byte;
   logic [2:0] s_cnt;
   logic       s_act, s_dv, s_hold;

   mii_uart_mux #(.CHANNELS(1), .DEPTH_LOG2(7), .FRAME_MODE(0)) dut_raw (
      .clk(clk), .reset(reset), .ch_rdy(r_rdy), .ch_q(r_q), .ch_en(r_en),
      .tx_active(r_act), .tx_dv(r_dv), .tx_byte(r_byte), .overflow(r_ovf), .fifo_count(r_cnt));
   mii_uart_mux #(.CHANNELS(2), .DEPTH_LOG2(7), .FRAME_MODE(1)) dut_frm (
      .clk(clk), .reset(reset), .ch_rdy(f_rdy), .ch_q(f_q), .ch_en(f_en),
      .tx_active(f_act), .tx_dv(f_dv), .tx_byte(f_byte), .overflow(f_ovf), .fifo_count(f_cnt));
   mii_uart_mux #(.CHANNELS(1), .DEPTH_LOG2(2), .FRAME_MODE(0)) dut_full (
      .clk(clk), .reset(reset), .ch_rdy(s_rdy), .ch_q(s_q), .ch_en(s_en),
      .tx_active(s_act), .tx_dv(s_dv), .tx_byte(s_byte), .overflow(s_ovf), .fifo_count(s_cnt));

   // UART models: busy for three cycles after each tx_dv; bytes logged as accepted.
   logic [3:0] r_busy = 4'd0, f_busy = 4'd0, s_busy = 4'd0;
   logic [7:0] r_log [256];
   logic [7:0] f_log [256];
   logic [7:0] s_log [256];
   int r_n = 0, f_n = 0, s_n = 0;

   always @(posedge clk) begin
      if (r_dv) begin r_busy <= 4'd3; r_log[8'(r_n)] <= r_byte; r_n <= r_n + 1; end
      else if (r_busy != 4'd0) r_busy <= r_busy - 4'd1;
   end
   always @(posedge clk) begin
      if (f_dv) begin f_busy <= 4'd3; f_log[8'(f_n)] <= f_byte; f_n <= f_n + 1; end
      else if (f_busy != 4'd0) f_busy <= f_busy - 4'd1;
   end
   always @(posedge clk) begin
      if (s_dv) begin s_busy <= 4'd3; s_log[8'(s_n)] <= s_byte; s_n <= s_n + 1; end
      else if (s_busy != 4'd0) s_busy <= s_busy - 4'd1;
   end
   assign r_act = (r_busy != 4'd0);
   assign f_act = (f_busy != 4'd0);
   assign s_act = s_hold | (s_busy != 4'd0);

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int log_n(input int which);
      case (which)
         0:       return r_n;
         1:       return f_n;
         default: return s_n;
      endcase
   endfunction

   function automatic logic [7:0] log_at(input int which, input int idx);
      case (which)
         0:       return r_log[8'(idx)];
         1:       return f_log[8'(idx)];
         default: return s_log[8'(idx)];
      endcase
   endfunction

   // Waits (bounded) for exp_q.size() bytes after index start, then compares them.
   task automatic expect_bytes(input string tag, input int which, input int start);
      int target = start + exp_q.size();
      for (int k = 0; k < 2000 && log_n(which) < target; k++) tick();
      check_eq({tag, "_count"}, log_n(which), target);
      for (int i = 0; i < exp_q.size(); i++)
         check_eq($sformatf("%s[%0d]", tag, i), log_at(which, start + i), exp_q[i]);
   endtask

   task automatic pulse_r(input logic [7:0] b);
      r_q = b; r_rdy = 1'b1; tick(); r_rdy = 1'b0; tick(); tick();
   endtask

   task automatic pulse_s(input logic [7:0] b);
      s_q = b; s_rdy = 1'b1; tick(); s_rdy = 1'b0; tick(); tick();
   endtask

   task automatic pulse_f(input int ch, input logic [7:0] b);
      f_q[8*ch +: 8] = b; f_rdy[ch] = 1'b1; tick(); f_rdy[ch] = 1'b0; tick(); tick();
   endtask

   task automatic pair_f(input logic [7:0] b0, input logic [7:0] b1);
      f_q = {b1, b0}; f_rdy = 2'b11; tick(); f_rdy = 2'b00; tick(); tick();
   endtask

   initial begin
      int s0;
      bit found;
      reset = 1'b1;
      r_rdy = 1'b0; r_en = 1'b0; r_q = 8'h00;
      f_rdy = 2'b00; f_en = 2'b00; f_q = 16'h0000;
      s_rdy = 1'b0; s_en = 1'b0; s_q = 8'h00; s_hold = 1'b0;
      repeat (3) tick();
      check_eq("rst_tx_dv", {r_dv, f_dv, s_dv}, 3'b000);
      check_eq("rst_tx_byte", {r_byte, f_byte, s_byte}, 24'h000000);
      check_eq("rst_overflow", {r_ovf, f_ovf, s_ovf}, 4'b0000);
      check_eq("rst_count", {r_cnt, f_cnt, s_cnt}, 19'h00000);
      reset = 1'b0;
      tick();

      // Raw mode with the N+1 write / N+2 pop / N+3 tx_dv latency.
      r_q = 8'h41; r_rdy = 1'b1;
      tick(); r_rdy = 1'b0;
      tick(); check_eq("lat_count_n1", r_cnt, 8'd1);
      tick(); check_eq("lat_dv_n2", r_dv, 1'b0);
              check_eq("lat_count_n2", r_cnt, 8'd0);
      tick(); check_eq("lat_dv_n3", r_dv, 1'b1);
              check_eq("lat_byte_n3", r_byte, 8'h41);
      r_en = 1'b1;
      pulse_r(8'h7E);
      pulse_r(8'h00);
      r_en = 1'b0;
      exp_q = {8'h41, 8'h7E, 8'h00};
      expect_bytes("raw", 0, 0);
      repeat (40) tick();
      check_eq("raw_no_extra", r_n, 3);
      check_eq("raw_overflow", r_ovf, 1'b0);

      // Framed: SOF ch1, data ch0, data ch1 incl. escape, EOF ch1.
      s0 = f_n;
      f_en[1] = 1'b1; tick(); tick(); tick();
      pulse_f(0, 8'h33);
      pulse_f(1, 8'h55);
      pulse_f(1, 8'h7D);
      f_en[1] = 1'b0; tick(); tick(); tick();
      exp_q = {8'h7E, 8'h91, 8'h7E, 8'h80, 8'h33, 8'h7E, 8'h81, 8'h55,
               8'h7D, 8'h5D, 8'h7E, 8'hA1};
      expect_bytes("frame", 1, s0);

      // Simultaneous pairs: round robin resumes after the last grant.
      s0 = f_n;
      pair_f(8'h11, 8'h22);
      pulse_f(0, 8'h7E);
      pair_f(8'h44, 8'h66);
      exp_q = {8'h7E, 8'h80, 8'h11, 8'h7E, 8'h81, 8'h22, 8'h7E, 8'h80, 8'h7D, 8'h5E,
               8'h7E, 8'h81, 8'h66, 8'h7E, 8'h80, 8'h44};
      expect_bytes("pair", 1, s0);
      check_eq("pair_overflow", f_ovf, 2'b00);

      // Full FIFO with tx_active held, then an overrun of the held pending byte.
      s_hold = 1'b1;
      pulse_s(8'hA0); pulse_s(8'hA1); pulse_s(8'hA2);
      pulse_s(8'hA3); pulse_s(8'hA4); pulse_s(8'hA5);
      check_eq("full_count", s_cnt, 3'd4);
      check_eq("full_no_ovf", s_ovf, 1'b0);
      repeat (5) tick();
      check_eq("full_count_hold", s_cnt, 3'd4);
      pulse_s(8'hA6);
      check_eq("overrun_flag", s_ovf, 1'b1);
      check_eq("full_nothing_sent", s_n, 0);
      s_hold = 1'b0;
      exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      expect_bytes("drain", 2, 0);
      repeat (40) tick();
      check_eq("drain_no_extra", s_n, 6);
      check_eq("overrun_sticky", s_ovf, 1'b1);
      check_eq("drain_count", s_cnt, 3'd0);

      // Reset while the escape's second byte is waiting in EMIT2.
      f_q[7:0] = 8'h7D; f_rdy[0] = 1'b1;
      tick(); f_rdy = 2'b10; f_q[15:8] = 8'h22;
      tick(); f_rdy = 2'b00;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         tick();
         if (f_dv === 1'b1 && f_byte == 8'h7D) found = 1'b1;
      end
      check_eq("esc_first_seen", found, 1'b1);
      check_eq("pre_reset_count", f_cnt, 8'd1);
      reset = 1'b1;
      tick();
      check_eq("mid_rst_dv", f_dv, 1'b0);
      check_eq("mid_rst_count", f_cnt, 8'd0);
      check_eq("mid_rst_byte", f_byte, 8'h00);
      check_eq("mid_rst_ovf_clr", s_ovf, 1'b0);
      reset = 1'b0;
      s0 = f_n;
      tick();
      pulse_f(0, 8'h5A);
      exp_q = {8'h7E, 8'h80, 8'h5A};
      expect_bytes("post_rst", 1, s0);
      repeat (40) tick();
      check_eq("post_rst_no_extra", f_n, s0 + 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
